// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at all-ones once reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: load-use, taken branch and data-memory
// wait hazards, with a wait timeout abort and saturating perf counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_rs1_decode,
    input  logic [REG_ADDR_W-1:0] i_rs2_decode,
    input  logic                  i_use_rs1_decode,
    input  logic                  i_use_rs2_decode,
    input  logic [REG_ADDR_W-1:0] i_rd_execute,
    input  logic                  i_mem_read_execute,
    input  logic                  i_pc_sel_execute,
    input  logic                  i_mem_req_memory,
    input  logic                  i_mem_ready_memory,
    input  logic                  i_cnt_clear,
    output logic                  o_stall_fetch,
    output logic                  o_stall_decode,
    output logic                  o_stall_execute,
    output logic                  o_stall_memory,
    output logic                  o_flush_decode,
    output logic                  o_flush_execute,
    output logic                  o_flush_writeback,
    output logic                  o_mem_abort,
    output logic                  o_mem_timeout,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    // Wait counter only needs to reach TIMEOUT-1
    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                mem_wait;
    logic                load_use;

    assign mem_wait = i_mem_req_memory & ~i_mem_ready_memory;

    assign load_use = i_mem_read_execute && (i_rd_execute != REG_X0) &&
                      ((i_use_rs1_decode && (i_rs1_decode == i_rd_execute)) ||
                       (i_use_rs2_decode && (i_rs2_decode == i_rd_execute)));

    // State, wait counter and sticky timeout flag
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= RUN;
            wait_cnt      <= '0;
            o_mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ABORT) begin
                o_mem_timeout <= 1'b1;
            end
        end
    end

    // Next state: the RUN cycle that first sees the wait counts as stall #1
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (!mem_wait) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ABORT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ABORT: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Mealy stall/flush outputs; forced quiet while reset is held
    always_comb begin
        o_stall_fetch     = 1'b0;
        o_stall_decode    = 1'b0;
        o_stall_execute   = 1'b0;
        o_stall_memory    = 1'b0;
        o_flush_decode    = 1'b0;
        o_flush_execute   = 1'b0;
        o_flush_writeback = 1'b0;
        o_mem_abort       = 1'b0;
        if (i_reset) begin
            if (state == ABORT) begin
                o_mem_abort       = 1'b1;
                o_flush_writeback = 1'b1;
            end else if (mem_wait) begin
                o_stall_fetch     = 1'b1;
                o_stall_decode    = 1'b1;
                o_stall_execute   = 1'b1;
                o_stall_memory    = 1'b1;
                o_flush_writeback = 1'b1;
            end else if (i_pc_sel_execute) begin
                o_flush_decode    = 1'b1;
                o_flush_execute   = 1'b1;
            end else if (load_use) begin
                o_stall_fetch     = 1'b1;
                o_stall_decode    = 1'b1;
                o_flush_execute   = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_reset),
        .inc   (o_stall_fetch),
        .clr   (i_cnt_clear),
        .count (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_reset),
        .inc   (o_flush_decode),
        .clr   (i_cnt_clear),
        .count (o_flush_cnt)
    );

endmodule
